// File: rtl/d_flip_flop.sv
// -----------------------------------------------------------------------------
// d_flip_flop
//   Parameterized D register with load enable, synchronous clear and a
//   complementary output. This is the basic storage element of the block.
//
//   Parameters
//     WIDTH    data width in bits
//     RST_VAL  value held in q while rst is low and loaded by clr
//
//   Ports
//     clk   in   1      system clock, rising edge
//     rst   in   1      asynchronous active-low reset
//     d     in   WIDTH  data to capture
//     en    in   1      load enable, active-high
//     clr   in   1      synchronous clear to RST_VAL, active-high, beats en
//     q     out  WIDTH  registered data
//     q_n   out  WIDTH  bitwise complement of q
//
// d_flip_flop_checker
//   Observer for the same signal bundle. Each property has one bit in err
//   (sticky failure) and one bit in cov (sticky antecedent hit):
//     bit 0  P1  q_n == ~q at every edge, reset included
//     bit 1  P2  q == RST_VAL while rst is low
//     bit 2  P3  clr at the previous edge   -> q == RST_VAL
//     bit 3  P4  en (no clr) previous edge  -> q == d sampled at that edge
//     bit 4  P5  idle previous edge         -> q == q sampled at that edge
//     bit 5  P6  q/q_n never X/Z once reset has been asserted
//
//   Extra ports
//     chk_rst_n  in   1  async active-low clear of the checker's own flags;
//                        kept apart from rst so reset-time failures stick
//     err        out  6  sticky failure flags, one per property
//     cov        out  6  sticky cover flags, one per property antecedent
// -----------------------------------------------------------------------------
module d_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

    // Derived rather than stored so it can never disagree with q.
    assign q_n = ~q;

endmodule

module d_flip_flop_checker #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] q_n,
    output logic [5:0]       err,
    output logic [5:0]       cov
);

    // Inputs and q as seen at the previous edge; h_valid says rst was high.
    logic             h_valid;
    logic             h_clr;
    logic             h_en;
    logic [WIDTH-1:0] h_d;
    logic [WIDTH-1:0] h_q;
    logic             seen_rst;
    logic [5:0]       fail;
    logic [5:0]       hit;

    // Arms the X/Z check on the first reset assertion and never disarms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_rst <= 1'b1;
        end
    end

    always_comb begin
        fail = '0;
        hit  = '0;

        hit[0]  = 1'b1;
        fail[0] = (q_n != ~q);

        hit[1]  = !rst;
        fail[1] = !rst && (q != RST_VAL);

        // A reset that arrives between edges overrides the capture, so the
        // history checks need rst high at both ends of the interval.
        hit[2]  = h_valid && rst && h_clr;
        fail[2] = hit[2] && (q != RST_VAL);

        hit[3]  = h_valid && rst && !h_clr && h_en;
        fail[3] = hit[3] && (q != h_d);

        hit[4]  = h_valid && rst && !h_clr && !h_en;
        fail[4] = hit[4] && (q != h_q);

        hit[5]  = seen_rst && rst;
        fail[5] = hit[5] && ($isunknown(q) || $isunknown(q_n));
    end

    always_ff @(posedge clk or negedge chk_rst_n) begin
        if (!chk_rst_n) begin
            err     <= '0;
            cov     <= '0;
            h_valid <= 1'b0;
            h_clr   <= 1'b0;
            h_en    <= 1'b0;
            h_d     <= '0;
            h_q     <= '0;
        end else begin
            err     <= err | fail;
            cov     <= cov | hit;
            h_valid <= rst;
            h_clr   <= clr;
            h_en    <= en;
            h_d     <= d;
            h_q     <= q;
        end
    end

endmodule

// File: tb/tb_d_flip_flop.sv
module tb_d_flip_flop;

    localparam int         WIDTH   = 8;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_rst_n;
    logic [7:0] d;
    logic       en;
    logic       clr;
    logic [7:0] q;
    logic [7:0] q_n;
    logic       inj;
    logic [7:0] q_n_bad;
    logic [5:0] err_main;
    logic [5:0] cov_main;
    logic [5:0] err_inj;
    logic [5:0] cov_inj;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: the value q must hold, tracked from the behavioural rules.
    logic [7:0] mq;

    always #5 clk = ~clk;

    d_flip_flop #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .en  (en),
        .clr (clr),
        .q   (q),
        .q_n (q_n)
    );

    d_flip_flop_checker #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) chk_main (
        .clk       (clk),
        .rst       (rst),
        .chk_rst_n (chk_rst_n),
        .d         (d),
        .en        (en),
        .clr       (clr),
        .q         (q),
        .q_n       (q_n),
        .err       (err_main),
        .cov       (cov_main)
    );

    // Second checker sees a q_n that can be corrupted on demand.
    assign q_n_bad = q_n ^ {WIDTH{inj}};

    d_flip_flop_checker #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) chk_inj (
        .clk       (clk),
        .rst       (rst),
        .chk_rst_n (chk_rst_n),
        .d         (d),
        .en        (en),
        .clr       (clr),
        .q         (q),
        .q_n       (q_n_bad),
        .err       (err_inj),
        .cov       (cov_inj)
    );

    // One clocked transaction: inputs applied at the falling edge, the model
    // advanced by the rules at the rising edge, outputs settled 1 ns later.
    task automatic drive(input logic [7:0] dv, input logic env, input logic clrv);
        @(negedge clk);
        d   = dv;
        en  = env;
        clr = clrv;
        @(posedge clk);
        if (!rst)     mq = RST_VAL;
        else if (clr) mq = RST_VAL;
        else if (en)  mq = d;
        #1;
    endtask

    task automatic test_reset();
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (q !== 8'hA5) $display("FAIL reset_q: got %h want %h", q, 8'hA5);
        else pass_cnt++;
        total_cnt++;
        if (q_n !== 8'h5A) $display("FAIL reset_q_n: got %h want %h", q_n, 8'h5A);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        mq  = RST_VAL;
    endtask

    task automatic test_load();
        drive(8'h12, 1'b1, 1'b0);
        total_cnt++;
        if (q !== 8'h12 || q_n !== 8'hED)
            $display("FAIL load_12: got q=%h q_n=%h want q=12 q_n=ED", q, q_n);
        else pass_cnt++;
        drive(8'h34, 1'b1, 1'b0);
        total_cnt++;
        if (q !== 8'h34 || q_n !== 8'hCB)
            $display("FAIL load_34: got q=%h q_n=%h want q=34 q_n=CB", q, q_n);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0);
            total_cnt++;
            if (q !== 8'h34 || q !== mq)
                $display("FAIL hold_%0d: got %h want %h", i, q, 8'h34);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_priority();
        drive(8'h77, 1'b1, 1'b1);
        total_cnt++;
        if (q !== 8'hA5) $display("FAIL clr_priority: got %h want %h", q, 8'hA5);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(8'h3C, 1'b1, 1'b0);
        total_cnt++;
        if (q !== 8'h3C) $display("FAIL preload_3c: got %h want %h", q, 8'h3C);
        else pass_cnt++;
        en = 1'b0;
        #2;
        rst = 1'b0;
        mq  = RST_VAL;
        #1;
        total_cnt++;
        if (q !== 8'hA5 || q_n !== 8'h5A)
            $display("FAIL async_reset: got q=%h q_n=%h want q=A5 q_n=5A", q, q_n);
        else pass_cnt++;
    endtask

    task automatic test_release_edge();
        d   = 8'h55;
        en  = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        // The release lands on the edge itself: the register has already
        // sampled rst low at this edge, so no capture may happen.
        rst <= 1'b1;
        #1;
        total_cnt++;
        if (q !== 8'hA5) $display("FAIL release_edge: got %h want %h", q, 8'hA5);
        else pass_cnt++;
        drive(8'h55, 1'b1, 1'b0);
        total_cnt++;
        if (q !== 8'h55) $display("FAIL first_capture: got %h want %h", q, 8'h55);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic       ren;
        logic       rclr;
        for (int i = 0; i < 25; i++) begin
            rd   = 8'($urandom);
            ren  = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 3) == 0);
            drive(rd, ren, rclr);
            total_cnt++;
            if (q !== mq || q_n !== ~mq)
                $display("FAIL random_%0d: got q=%h q_n=%h want q=%h q_n=%h",
                         i, q, q_n, mq, ~mq);
            else pass_cnt++;
        end
    endtask

    task automatic test_checker();
        total_cnt++;
        if (err_main !== 6'h00) $display("FAIL chk_clean: got err=%b want 000000", err_main);
        else pass_cnt++;
        total_cnt++;
        if (cov_main !== 6'h3F) $display("FAIL chk_cover: got cov=%b want 111111", cov_main);
        else pass_cnt++;
        total_cnt++;
        if (err_inj !== 6'h00) $display("FAIL chk_inj_idle: got err=%b want 000000", err_inj);
        else pass_cnt++;
        @(negedge clk);
        inj = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        inj = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (err_inj !== 6'b000001)
            $display("FAIL chk_p1_inject: got err=%b want 000001", err_inj);
        else pass_cnt++;
        total_cnt++;
        if (err_main !== 6'h00) $display("FAIL chk_main_after: got err=%b want 000000", err_main);
        else pass_cnt++;
    endtask

    initial begin
        #1000;
        $display("FAIL watchdog: simulation reached 1000 ns without finishing");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        chk_rst_n = 1'b0;
        d         = '0;
        en        = 1'b0;
        clr       = 1'b0;
        inj       = 1'b0;
        mq        = RST_VAL;
        #1 rst = 1'b0;
        #1 chk_rst_n = 1'b1;

        test_reset();
        test_load();
        test_hold();
        test_clear_priority();
        test_async_reset();
        test_release_edge();
        test_random();
        test_checker();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Parameterized D-type register with load enable, synchronous clear and complementary outputs. It is the basic storage element of the design and sits behind the block's signal bundle, which carries the top-level clock and reset. A companion checker binds to the same bundle and continuously checks the register's behaviour. The top level generates the clock and holds reset for several cycles after power-up so the system can stabilize.

## Interface

Parameters:
- WIDTH, 1: data width in bits.
- RST_VAL, '0: value loaded into q while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst  input  1  asynchronous, active-low reset; one clock domain only.
- d  input  WIDTH  data to capture.
- en  input  1  load enable; active-high.
- clr  input  1  synchronous clear; active-high; loads RST_VAL.
- q  output  WIDTH  registered data.
- q_n  output  WIDTH  bitwise complement of q.

## Operation

- Reset (rst == 0): q = RST_VAL and q_n = ~RST_VAL immediately. No clock edge is required. All other inputs are ignored while reset is low.
- At each rising clk edge with rst == 1, in priority order:
  - clr == 1: q <= RST_VAL (overrides en).
  - en == 1: q <= d.
  - otherwise: q holds its value.
- q_n is derived from q, not separately stored, so it can never disagree with q.
- No internal state other than q.

Checker (separate module on the same bundle; required deliverable):
- P1: q_n == ~q at every clock edge and while in reset.
- P2: while rst == 0, q == RST_VAL.
- P3: if rst && clr at a clock edge, q == RST_VAL after that edge.
- P4: if rst && !clr && en at a clock edge, q == $past(d) after that edge.
- P5: if rst && !clr && !en at a clock edge, q == $past(q) after that edge.
- P6: q and q_n are never X/Z after the first reset assertion.
- Each property fires a labelled error message on failure.
- Each property has a cover point for its antecedent.
- Checks are disabled while rst == 0, except P1 and P2.

## Timing

- Capture latency is 1 cycle: d sampled at edge N appears on q after edge N.
- Reset assertion is asynchronous: q changes within the same delta, independent of clk.
- Reset deassertion is released synchronously to clk at the system level.
  - The first capture happens on the first rising edge where rst is already 1.
  - An edge coincident with the reset release does not capture.
- If reset is asserted mid-operation, it overrides any pending capture; the value captured on the prior edge is lost to RST_VAL.
- If clr and en are both 1 at the same edge, clr wins.
- Reference timing: the clock toggles every 5 ns (10 ns period).
  - Reset is held for 10 cycles after the first edge.
  - Simulation ends at a 1000 ns global timeout.
- No combinational path from d, en or clr to q or q_n.

## Test plan

- Reset: WIDTH=8, RST_VAL=8'hA5; drive rst=0 mid-cycle with q=8'h3C.
  - Required: q=8'hA5 and q_n=8'h5A immediately, before the next edge.
- Load: after reset release, en=1, d=8'h12 then 8'h34 on consecutive edges.
  - Required: q=8'h12 then 8'h34, each one cycle later; q_n=8'hED then 8'hCB.
- Hold: q=8'h34, en=0, d toggles 8'hFF/8'h00 for 5 cycles.
  - Required: q stays 8'h34 throughout.
- Clear priority: clr=1 and en=1 with d=8'h77 on the same edge.
  - Required: q=8'hA5 after the edge, not 8'h77.
- Release edge: d=8'h55, en=1, rst goes high exactly at a rising edge.
  - Required: q stays 8'hA5 through that edge, then q=8'h55 after the next edge.
- Checker sanity: inject a forced q_n mismatch for one cycle.
  - Required: P1 reports an error; all other runs complete with zero checker errors and every cover point hit.
